// File: rtl/pixel_coordinate_scanner.sv
// Raster pixel front-end: tags each accepted pixel with original and
// decimated coordinates, frame-boundary flags and a completed-frame count.
module pixel_coordinate_scanner #(
   parameter int FRAME_WIDTH       = 100,
   parameter int FRAME_HEIGHT      = 24,
   parameter int COORD_WIDTH       = 12,
   parameter int PIXEL_WIDTH       = 12,
   parameter int SCALE_LOG2        = 1,
   parameter int FRAME_COUNT_WIDTH = 8
) (
   input  logic                         clk_fpga,
   input  logic                         reset_fpga,
   input  logic                         i_enable,
   input  logic                         i_pixel_valid,
   input  logic [PIXEL_WIDTH-1:0]       i_pixel,
   output logic                         o_pixel_ready,
   output logic                         o_pixel_valid,
   input  logic                         i_out_ready,
   output logic [PIXEL_WIDTH-1:0]       o_pixel,
   output logic [COORD_WIDTH-1:0]       o_ori_x,
   output logic [COORD_WIDTH-1:0]       o_ori_y,
   output logic [COORD_WIDTH-1:0]       o_resize_x,
   output logic [COORD_WIDTH-1:0]       o_resize_y,
   output logic                         o_resize_hit,
   output logic                         o_end_of_line,
   output logic                         o_end_of_frame,
   output logic [FRAME_COUNT_WIDTH-1:0] o_frame_count,
   output logic                         o_busy
);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      FRAME_DONE
   } state_t;

   localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(FRAME_WIDTH - 1);
   localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(FRAME_HEIGHT - 1);
   // Mask of the coordinate bits dropped by decimation; empty when unscaled.
   localparam logic [COORD_WIDTH-1:0] MASK =
      COORD_WIDTH'((1 << SCALE_LOG2) - 1);

   state_t                 state;
   logic [COORD_WIDTH-1:0] x;
   logic [COORD_WIDTH-1:0] y;
   logic                   accept;
   logic                   x_last;
   logic                   y_last;
   logic                   on_grid;

   assign o_pixel_ready = (state == SCAN) && (!o_pixel_valid || i_out_ready);
   assign accept        = i_pixel_valid && o_pixel_ready;
   assign x_last        = (x == X_LAST);
   assign y_last        = (y == Y_LAST);
   assign on_grid       = ((x & MASK) == '0) && ((y & MASK) == '0);
   assign o_busy        = (state != IDLE);

   always_ff @(posedge clk_fpga) begin
      if (reset_fpga) begin
         state          <= IDLE;
         x              <= '0;
         y              <= '0;
         o_pixel_valid  <= 1'b0;
         o_pixel        <= '0;
         o_ori_x        <= '0;
         o_ori_y        <= '0;
         o_resize_x     <= '0;
         o_resize_y     <= '0;
         o_resize_hit   <= 1'b0;
         o_end_of_line  <= 1'b0;
         o_end_of_frame <= 1'b0;
         o_frame_count  <= '0;
      end else begin
         unique case (state)
            IDLE:       if (i_enable) state <= SCAN;
            SCAN:       if (accept && x_last && y_last) state <= FRAME_DONE;
            FRAME_DONE: state <= i_enable ? SCAN : IDLE;
            default:    state <= IDLE;
         endcase

         if (accept) begin
            o_pixel_valid  <= 1'b1;
            o_pixel        <= i_pixel;
            o_ori_x        <= x;
            o_ori_y        <= y;
            o_resize_x     <= x >> SCALE_LOG2;
            o_resize_y     <= y >> SCALE_LOG2;
            o_resize_hit   <= on_grid;
            o_end_of_line  <= x_last;
            o_end_of_frame <= x_last && y_last;
            if (x_last) begin
               x <= '0;
               y <= y_last ? '0 : y + 1'b1;
               if (y_last) o_frame_count <= o_frame_count + 1'b1;
            end else begin
               x <= x + 1'b1;
            end
         end else if (i_out_ready) begin
            o_pixel_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pixel_coordinate_scanner.sv
// Bench for pixel_coordinate_scanner: two 4x2 instances (scaled and
// unscaled) against an index-based reference model plus literal tables.
module tb_pixel_coordinate_scanner;

   localparam int W = 4;
   localparam int H = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        pv = 1'b0;
   logic [11:0] pix = '0;
   logic        ordy = 1'b1;

   logic        a_rdy, a_vld, a_hit, a_eol, a_eof, a_busy;
   logic [11:0] a_pix, a_x, a_y, a_rx, a_ry;
   logic [1:0]  a_fc;
   logic        b_rdy, b_vld, b_hit, b_eol, b_eof, b_busy;
   logic [11:0] b_pix, b_x, b_y, b_rx, b_ry;
   logic [7:0]  b_fc;

   always #5 clk = ~clk;

   pixel_coordinate_scanner #(
      .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .COORD_WIDTH(12),
      .PIXEL_WIDTH(12), .SCALE_LOG2(1), .FRAME_COUNT_WIDTH(2)
   ) dut_a (
      .clk_fpga(clk), .reset_fpga(rst), .i_enable(en),
      .i_pixel_valid(pv), .i_pixel(pix), .o_pixel_ready(a_rdy),
      .o_pixel_valid(a_vld), .i_out_ready(ordy), .o_pixel(a_pix),
      .o_ori_x(a_x), .o_ori_y(a_y), .o_resize_x(a_rx), .o_resize_y(a_ry),
      .o_resize_hit(a_hit), .o_end_of_line(a_eol),
      .o_end_of_frame(a_eof), .o_frame_count(a_fc), .o_busy(a_busy)
   );

   pixel_coordinate_scanner #(
      .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .COORD_WIDTH(12),
      .PIXEL_WIDTH(12), .SCALE_LOG2(0), .FRAME_COUNT_WIDTH(8)
   ) dut_b (
      .clk_fpga(clk), .reset_fpga(rst), .i_enable(en),
      .i_pixel_valid(pv), .i_pixel(pix), .o_pixel_ready(b_rdy),
      .o_pixel_valid(b_vld), .i_out_ready(ordy), .o_pixel(b_pix),
      .o_ori_x(b_x), .o_ori_y(b_y), .o_resize_x(b_rx), .o_resize_y(b_ry),
      .o_resize_hit(b_hit), .o_end_of_line(b_eol),
      .o_end_of_frame(b_eof), .o_frame_count(b_fc), .o_busy(b_busy)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", n, act, exp, $time);
      end
   endtask

   // Reference model: phase 0=idle 1=scan 2=frame done; coordinates come
   // from the running index of accepted pixels within the frame.
   int m_ph = 0, m_idx = 0, m_ov = 0, m_pix = 0;
   int m_x = 0, m_y = 0, m_tag = 0, m_frames = 0;

   function automatic bit m_ready();
      return (m_ph == 1) && (m_ov == 0 || ordy);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_ph <= 0; m_idx <= 0; m_ov <= 0; m_pix <= 0;
         m_x <= 0; m_y <= 0; m_tag <= 0; m_frames <= 0;
      end else begin
         if (pv && m_ready()) begin
            m_ov <= 1; m_pix <= int'(pix); m_tag <= 1;
            m_x <= m_idx % W; m_y <= m_idx / W;
            if (m_idx == W * H - 1) begin
               m_idx <= 0; m_frames <= m_frames + 1;
            end else begin
               m_idx <= m_idx + 1;
            end
         end else if (m_ov != 0 && ordy) begin
            m_ov <= 0;
         end
         if (m_ph == 0 && en) m_ph <= 1;
         else if (m_ph == 1 && pv && m_ready() && m_idx == W * H - 1) m_ph <= 2;
         else if (m_ph == 2) m_ph <= en ? 1 : 0;
      end
   end

   typedef struct {
      int pix; int x; int y; int hit; int eol; int eof;
   } ent_t;
   ent_t q[$];
   int   fcq[$];
   int   last_fc = 0;

   always @(negedge clk) begin
      chk("a_ready", a_rdy, m_ready());
      chk("a_valid", a_vld, m_ov);
      chk("a_busy", a_busy, m_ph != 0);
      chk("a_pixel", a_pix, m_pix);
      chk("a_ori_x", a_x, m_x);
      chk("a_ori_y", a_y, m_y);
      chk("a_resize_x", a_rx, m_x / 2);
      chk("a_resize_y", a_ry, m_y / 2);
      chk("a_hit", a_hit, m_tag != 0 && m_x % 2 == 0 && m_y % 2 == 0);
      chk("a_eol", a_eol, m_x == W - 1);
      chk("a_eof", a_eof, m_x == W - 1 && m_y == H - 1);
      chk("a_frame_count", a_fc, m_frames % 4);
      chk("b_ready", b_rdy, m_ready());
      chk("b_valid", b_vld, m_ov);
      chk("b_pixel", b_pix, m_pix);
      chk("b_ori_x", b_x, m_x);
      chk("b_ori_y", b_y, m_y);
      chk("b_resize_x", b_rx, m_x);
      chk("b_resize_y", b_ry, m_y);
      chk("b_hit", b_hit, m_tag);
      chk("b_eof", b_eof, m_x == W - 1 && m_y == H - 1);
      chk("b_frame_count", b_fc, m_frames % 256);
      if (a_vld && ordy)
         q.push_back('{int'(a_pix), int'(a_x), int'(a_y),
                       int'(a_hit), int'(a_eol), int'(a_eof)});
      if (int'(a_fc) != last_fc) begin
         fcq.push_back(int'(a_fc));
         last_fc = int'(a_fc);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; pv = 1'b0; en = 1'b0; ordy = 1'b1;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic send(input int v);
      int n;
      bit r;
      pix = 12'(v); pv = 1'b1; n = 0; r = 1'b0;
      while (!r && n < 60) begin
         @(negedge clk);
         r = a_rdy;
         step();
         n++;
      end
      chk("send_accept", r, 1);
      pv = 1'b0;
   endtask

   int ex[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int ey[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
   int eh[8] = '{1, 0, 1, 0, 0, 0, 0, 0};
   int el[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
   int ef[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
   int efc[5] = '{1, 2, 3, 0, 1};
   bit stop;

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      do_reset();
      @(negedge clk);
      chk("rst_valid", a_vld, 0);
      chk("rst_ready", a_rdy, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_fc", a_fc, 0);
      #1;

      // full-rate frame
      en = 1'b1; q.delete();
      for (int i = 1; i <= 8; i++) send(i);
      repeat (4) step();
      chk("t1_count", q.size(), 8);
      for (int i = 0; i < q.size() && i < 8; i++) begin
         chk("t1_pix", q[i].pix, i + 1);
         chk("t1_x", q[i].x, ex[i]);
         chk("t1_y", q[i].y, ey[i]);
         chk("t1_hit", q[i].hit, eh[i]);
         chk("t1_eol", q[i].eol, el[i]);
         chk("t1_eof", q[i].eof, ef[i]);
      end
      chk("t1_fc", a_fc, 1);

      // backpressure
      do_reset();
      en = 1'b1; q.delete();
      send(1);
      ordy = 1'b0; pix = 12'd2; pv = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t2_ready", a_rdy, 0);
         chk("t2_valid", a_vld, 1);
         chk("t2_pix", a_pix, 1);
         chk("t2_x", a_x, 0);
         chk("t2_y", a_y, 0);
         step();
      end
      ordy = 1'b1;
      for (int i = 2; i <= 8; i++) send(i);
      repeat (4) step();
      chk("t2_count", q.size(), 8);
      for (int i = 0; i < q.size() && i < 8; i++) chk("t2_order", q[i].pix, i + 1);

      // enable drop mid-frame
      do_reset();
      en = 1'b1; q.delete();
      for (int i = 1; i <= 3; i++) send(i);
      en = 1'b0;
      for (int i = 4; i <= 8; i++) send(i);
      repeat (3) step();
      @(negedge clk);
      chk("t3_busy", a_busy, 0);
      chk("t3_fc", a_fc, 1);
      chk("t3_count", q.size(), 8);
      #1;
      pix = 12'd99; pv = 1'b1;
      repeat (4) step();
      @(negedge clk);
      chk("t3_ready", a_rdy, 0);
      chk("t3_ignored", q.size(), 8);
      #1;
      pv = 1'b0;

      // reset mid-frame
      do_reset();
      en = 1'b1;
      for (int i = 1; i <= 5; i++) send(i);
      rst = 1'b1;
      step();
      @(negedge clk);
      chk("t4_valid", a_vld, 0);
      chk("t4_pix", a_pix, 0);
      chk("t4_x", a_x, 0);
      chk("t4_y", a_y, 0);
      chk("t4_hit", b_hit, 0);
      chk("t4_busy", a_busy, 0);
      chk("t4_ready", a_rdy, 0);
      #1;
      rst = 1'b0; q.delete();
      send(6);
      repeat (2) step();
      chk("t4_count", q.size(), 1);
      if (q.size() > 0) begin
         chk("t4_first_x", q[0].x, 0);
         chk("t4_first_y", q[0].y, 0);
         chk("t4_first_pix", q[0].pix, 6);
      end
      chk("t4_fc", a_fc, 0);

      // frame counter wrap
      do_reset();
      fcq.delete();
      en = 1'b1;
      for (int i = 0; i < 40; i++) send(i);
      repeat (3) step();
      chk("t5_events", fcq.size(), 5);
      for (int i = 0; i < fcq.size() && i < 5; i++) chk("t5_fc_seq", fcq[i], efc[i]);
      chk("t5_fc_b", b_fc, 5);

      // random gaps, unscaled instance checked by the model every cycle
      do_reset();
      en = 1'b1; q.delete(); stop = 1'b0;
      fork
         begin
            for (int i = 1; i <= 16; i++) begin
               repeat ($urandom_range(0, 2)) step();
               send(i);
            end
            stop = 1'b1;
         end
         begin
            while (!stop) begin
               ordy = 1'($urandom_range(0, 1));
               step();
            end
            ordy = 1'b1;
         end
      join
      repeat (5) step();
      chk("t6_count", q.size(), 16);
      for (int i = 0; i < q.size() && i < 16; i++) chk("t6_order", q[i].pix, i + 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pixel_coordinate_scanner.md
Name: pixel_coordinate_scanner

Overview:
Parametrised pixel front-end for the face detection pipeline. It accepts a raster pixel stream through a valid/ready handshake and tags each pixel with its original (x,y) coordinates. It also computes decimated (resized) coordinates and a grid-hit flag for power-of-two downscaling. Outputs are registered, with end-of-line, end-of-frame and frame-count status, and feed the integral/line-buffer stage.

Parameters:
FRAME_WIDTH, 100, pixels per line (>=2)
FRAME_HEIGHT, 24, lines per frame (>=2)
COORD_WIDTH, 12, width of all coordinate outputs; must hold FRAME_WIDTH-1 and FRAME_HEIGHT-1
PIXEL_WIDTH, 12, pixel data width
SCALE_LOG2, 1, resize factor = 2^SCALE_LOG2 (0 = no resize)
FRAME_COUNT_WIDTH, 8, width of frame counter

Ports:
clk_fpga  in  1  single clock; all logic on rising edge
reset_fpga  in  1  synchronous, active-high reset
i_enable  in  1  level; allow scanning; sampled at frame boundaries
i_pixel_valid  in  1  upstream pixel present
i_pixel  in  PIXEL_WIDTH  upstream pixel data
o_pixel_ready  out  1  block accepts pixel this cycle
o_pixel_valid  out  1  output register holds a tagged pixel
i_out_ready  in  1  downstream accepts output this cycle
o_pixel  out  PIXEL_WIDTH  registered pixel
o_ori_x  out  COORD_WIDTH  original x of o_pixel
o_ori_y  out  COORD_WIDTH  original y of o_pixel
o_resize_x  out  COORD_WIDTH  o_ori_x >> SCALE_LOG2
o_resize_y  out  COORD_WIDTH  o_ori_y >> SCALE_LOG2
o_resize_hit  out  1  low SCALE_LOG2 bits of both ori coords are zero
o_end_of_line  out  1  o_ori_x == FRAME_WIDTH-1
o_end_of_frame  out  1  end_of_line and o_ori_y == FRAME_HEIGHT-1
o_frame_count  out  FRAME_COUNT_WIDTH  completed frames, wraps
o_busy  out  1  state != IDLE

Behaviour:
- Reset (reset_fpga=1 at clock edge) forces state IDLE; internal x/y counters 0; all outputs 0, including o_pixel_valid, o_pixel_ready and o_frame_count. Reset overrides every other input, including mid-frame; a partial frame is discarded and not counted.
- States: IDLE, SCAN, FRAME_DONE.
  - IDLE -> SCAN when i_enable=1.
  - SCAN -> FRAME_DONE on the cycle the last pixel of a frame (x=FRAME_WIDTH-1, y=FRAME_HEIGHT-1) is accepted.
  - FRAME_DONE lasts exactly 1 cycle, then goes to SCAN if i_enable=1, else IDLE.
- o_pixel_ready is combinational: (state==SCAN) && (!o_pixel_valid || i_out_ready). It does not depend on i_pixel_valid.
- Accept = i_pixel_valid && o_pixel_ready. On accept:
  - the output register loads i_pixel with the current counters;
  - o_pixel_valid=1 on the next cycle;
  - latency is 1 cycle.
- Output handshake: o_pixel_valid && i_out_ready without a simultaneous accept clears o_pixel_valid. Simultaneous accept and drain reloads the register, so full throughput of 1 pixel/clk is sustained. While o_pixel_valid=1 and i_out_ready=0, the output register and all tag outputs are held stable.
- Counters advance only on accept:
  - x increments;
  - at x=FRAME_WIDTH-1, x wraps to 0 and y increments;
  - at y=FRAME_HEIGHT-1 with x wrap, y wraps to 0.
- o_frame_count increments on entry to FRAME_DONE and wraps modulo 2^FRAME_COUNT_WIDTH.
- i_enable deasserted mid-frame has no effect until the frame completes. The block then passes through FRAME_DONE to IDLE with o_pixel_ready=0. An output still held in the register continues to drain normally in IDLE and FRAME_DONE.
- Tag outputs (ori, resize, hit, end flags) are registered together with o_pixel. They are meaningful only when o_pixel_valid=1 and hold their last values otherwise.
- SCALE_LOG2=0: o_resize_x/y equal o_ori_x/y and o_resize_hit=1 for every pixel.
- Upstream must hold i_pixel stable while i_pixel_valid=1 and unaccepted. Downstream may toggle i_out_ready freely.

Test Plan:
1. Override FRAME_WIDTH=4, FRAME_HEIGHT=2, SCALE_LOG2=1; i_enable=1, valid/ready constant 1, pixels 1..8 -> outputs 1..8 one cycle after each accept. Coords: (0,0)(1,0)(2,0)(3,0)(0,1)..(3,1). o_resize_hit=1 only for (0,0),(2,0). o_end_of_line on x=3; o_end_of_frame on pixel 8. o_pixel_ready=0 for 1 cycle (FRAME_DONE); o_frame_count 0->1.
2. Backpressure: i_out_ready=0 for 3 cycles after first output -> o_pixel_ready=0, o_pixel/coords frozen at value 1/(0,0). Resume -> no pixel lost or duplicated, order preserved.
3. Enable drop: i_enable=0 after pixel 3 of a 4x2 frame -> pixels 4..8 still accepted. Then FRAME_DONE -> IDLE, o_busy=0, o_frame_count=1, further i_pixel_valid ignored.
4. Reset mid-frame after 5 accepts -> next cycle all outputs 0, state IDLE. Re-enable -> next pixel tagged (0,0), o_frame_count=0.
5. Wrap: FRAME_COUNT_WIDTH=2, run 5 full frames -> o_frame_count sequence 1,2,3,0,1.
6. SCALE_LOG2=0, random valid/ready gaps over 2 frames -> o_resize equals ori coords and hit=1 on all outputs. Scoreboard matches the input order.
